// File: rtl/pe_pkg.sv
// Shared definitions for the PE stream driver: config field positions, FSM states
// and the per-phase beat count rule.
package pe_pkg;

  localparam int CONFIG_SIZE = 13;
  localparam int DATA_BITS   = 32;

  localparam int CFG_DW     = 12;
  localparam int CFG_RS_LSB = 10;
  localparam int CFG_U      = 9;
  localparam int CFG_P_LSB  = 7;
  localparam int CFG_F_LSB  = 2;
  localparam int CFG_Q_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    FILTER,
    IFMAP,
    DW_IPSUM,
    PW_IPSUM,
    OPSUM
  } state_t;

  // Counts are 1..16, so five bits always suffice.
  function automatic logic [4:0] phase_beats(
    input state_t     phase,
    input logic       dw,
    input logic [2:0] p,
    input logic [2:0] q,
    input logic [2:0] rs,
    input logic [1:0] u,
    input logic [4:0] col
  );
    logic [4:0] n;
    n = '0;
    case (phase)
      FILTER:   n = {2'b00, p} * {2'b00, rs};
      IFMAP:    n = (col == 5'd0) ? {2'b00, rs} : {3'b000, u};
      DW_IPSUM: n = dw ? {2'b00, q} : {2'b00, p};
      PW_IPSUM: n = {2'b00, p};
      OPSUM:    n = {2'b00, p};
      default:  n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pe_beat_fifo.sv
// Two-entry prefetch buffer between the buffer read port and the PE streams.
module pe_beat_fifo
  import pe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DATA_BITS-1:0] i_data,
  output logic [DATA_BITS-1:0] o_head,
  output logic [1:0]           o_count
);

  logic [DATA_BITS-1:0] r_mem [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/pe_stream_driver.sv
// Feeds one PE its filter/ifmap/ipsum beats from the local buffer in consumption order
// and writes the PE's opsum results back.
module pe_stream_driver
  import pe_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [CONFIG_SIZE-1:0] i_cfg,
  input  logic [ADDR_W-1:0]      i_filter_base,
  input  logic [ADDR_W-1:0]      i_ifmap_base,
  input  logic [ADDR_W-1:0]      i_ipsum_base,
  input  logic [ADDR_W-1:0]      i_opsum_base,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_mem_ren,
  output logic [ADDR_W-1:0]      o_mem_raddr,
  input  logic [DATA_BITS-1:0]   i_mem_rdata,
  output logic                   o_mem_wen,
  output logic [ADDR_W-1:0]      o_mem_waddr,
  output logic [DATA_BITS-1:0]   o_mem_wdata,
  output logic                   o_pe_en,
  output logic [CONFIG_SIZE-1:0] o_pe_config,
  output logic [DATA_BITS-1:0]   o_ifmap,
  output logic                   o_ifmap_valid,
  input  logic                   i_ifmap_ready,
  output logic [DATA_BITS-1:0]   o_filter,
  output logic                   o_filter_valid,
  input  logic                   i_filter_ready,
  output logic [DATA_BITS-1:0]   o_depthwise_ipsum,
  output logic                   o_depthwise_ipsum_valid,
  input  logic                   i_depthwise_ipsum_ready,
  output logic [DATA_BITS-1:0]   o_pointwise_ipsum,
  output logic                   o_pointwise_ipsum_valid,
  input  logic                   i_pointwise_ipsum_ready,
  input  logic [DATA_BITS-1:0]   i_opsum,
  input  logic                   i_opsum_valid,
  output logic                   o_opsum_ready
);

  state_t                 r_state;
  logic [CONFIG_SIZE-1:0] r_cfg;
  logic [ADDR_W-1:0]      r_fptr;
  logic [ADDR_W-1:0]      r_iptr;
  logic [ADDR_W-1:0]      r_pptr;
  logic [ADDR_W-1:0]      r_optr;
  logic [4:0]             r_issued;
  logic [4:0]             r_acked;
  logic [4:0]             r_col;
  logic                   r_pe_en;
  logic                   r_done;
  logic                   r_busy;
  logic                   r_inflight;

  logic [2:0]           w_p;
  logic [2:0]           w_q;
  logic [2:0]           w_rs;
  logic [1:0]           w_u;
  logic [4:0]           w_f;
  logic [4:0]           w_beats;
  logic                 w_stream;
  logic                 w_valid;
  logic                 w_ready;
  logic                 w_pop;
  logic [2:0]           w_occ;
  logic                 w_ren;
  logic [ADDR_W-1:0]    w_src_ptr;
  logic                 w_hs;
  logic                 w_last;
  logic [DATA_BITS-1:0] w_head;
  logic [1:0]           w_fifo_count;

  assign w_p  = {1'b0, r_cfg[CFG_P_LSB +: 2]} + 3'd1;
  assign w_q  = {1'b0, r_cfg[CFG_Q_LSB +: 2]} + 3'd1;
  assign w_rs = {1'b0, r_cfg[CFG_RS_LSB +: 2]} + 3'd1;
  assign w_u  = {1'b0, r_cfg[CFG_U]} + 2'd1;
  assign w_f  = r_cfg[CFG_F_LSB +: 5];

  assign w_beats  = phase_beats(r_state, r_cfg[CFG_DW], w_p, w_q, w_rs, w_u, r_col);
  assign w_stream = (r_state == FILTER) || (r_state == IFMAP) ||
                    (r_state == DW_IPSUM) || (r_state == PW_IPSUM);
  assign w_valid  = w_stream && (w_fifo_count != 2'd0);

  always_comb begin
    w_ready   = 1'b0;
    w_src_ptr = '0;
    case (r_state)
      FILTER:   begin w_ready = i_filter_ready;          w_src_ptr = r_fptr; end
      IFMAP:    begin w_ready = i_ifmap_ready;           w_src_ptr = r_iptr; end
      DW_IPSUM: begin w_ready = i_depthwise_ipsum_ready; w_src_ptr = r_pptr; end
      PW_IPSUM: begin w_ready = i_pointwise_ipsum_ready; w_src_ptr = r_pptr; end
      default:  begin w_ready = 1'b0;                    w_src_ptr = '0;     end
    endcase
  end

  // A word popped this cycle frees its slot, so back-to-back beats keep streaming.
  assign w_pop  = w_valid && w_ready;
  assign w_occ  = {1'b0, w_fifo_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_ren  = w_stream && (r_issued < w_beats) && (w_occ < 3'd2);
  assign w_hs   = w_stream ? w_pop : ((r_state == OPSUM) && i_opsum_valid);
  assign w_last = w_hs && (r_acked == (w_beats - 5'd1));

  pe_beat_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (i_mem_rdata),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cfg      <= '0;
      r_fptr     <= '0;
      r_iptr     <= '0;
      r_pptr     <= '0;
      r_optr     <= '0;
      r_issued   <= '0;
      r_acked    <= '0;
      r_col      <= '0;
      r_pe_en    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_pe_en    <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= w_ren;
      if (w_ren) begin
        r_issued <= r_issued + 5'd1;
        case (r_state)
          FILTER:             r_fptr <= r_fptr + ADDR_W'(1);
          IFMAP:              r_iptr <= r_iptr + ADDR_W'(1);
          DW_IPSUM, PW_IPSUM: r_pptr <= r_pptr + ADDR_W'(1);
          default:            ;
        endcase
      end
      if (w_hs) begin
        r_acked <= r_acked + 5'd1;
      end
      if ((r_state == OPSUM) && w_hs) begin
        r_optr <= r_optr + ADDR_W'(1);
      end
      if (w_last) begin
        r_issued <= '0;
        r_acked  <= '0;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cfg    <= i_cfg;
            r_fptr   <= i_filter_base;
            r_iptr   <= i_ifmap_base;
            r_pptr   <= i_ipsum_base;
            r_optr   <= i_opsum_base;
            r_issued <= '0;
            r_acked  <= '0;
            r_col    <= '0;
            r_pe_en  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= FILTER;
          end
        end
        FILTER:   if (w_last) r_state <= IFMAP;
        IFMAP:    if (w_last) r_state <= DW_IPSUM;
        DW_IPSUM: if (w_last) r_state <= r_cfg[CFG_DW] ? PW_IPSUM : OPSUM;
        PW_IPSUM: if (w_last) r_state <= OPSUM;
        OPSUM: begin
          if (w_last) begin
            if (r_col == w_f) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_col   <= r_col + 5'd1;
              r_state <= IFMAP;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pe_en     = r_pe_en;
  assign o_pe_config = r_cfg;
  assign o_mem_ren   = w_ren;
  assign o_mem_raddr = w_ren ? w_src_ptr : '0;

  assign o_opsum_ready = (r_state == OPSUM);
  assign o_mem_wen     = (r_state == OPSUM) && i_opsum_valid;
  assign o_mem_waddr   = o_mem_wen ? r_optr : '0;
  assign o_mem_wdata   = o_mem_wen ? i_opsum : '0;

  assign o_filter                = w_head;
  assign o_ifmap                 = w_head;
  assign o_depthwise_ipsum       = w_head;
  assign o_pointwise_ipsum       = w_head;
  assign o_filter_valid          = w_valid && (r_state == FILTER);
  assign o_ifmap_valid           = w_valid && (r_state == IFMAP);
  assign o_depthwise_ipsum_valid = w_valid && (r_state == DW_IPSUM);
  assign o_pointwise_ipsum_valid = w_valid && (r_state == PW_IPSUM);

endmodule

// File: tb/tb_pe_stream_driver.sv
// Randomized bench for pe_stream_driver: a beat-list model built from the dataflow rules
// is compared against the observed streams, read addresses and opsum writes.
module tb_pe_stream_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] cfg;
  logic [15:0] filterBase, ifmapBase, ipsumBase, opsumBase;
  logic [31:0] memRdata;
  logic        ifmapReady, filterReady, dwReady, pwReady;
  logic [31:0] opsum;
  logic        opsumValid;

  logic        busy, done, memRen, memWen, peEn, opsumReady;
  logic [15:0] memRaddr, memWaddr;
  logic [31:0] memWdata;
  logic [12:0] peConfig;
  logic [31:0] ifmapD, filterD, dwD, pwD;
  logic        ifmapValid, filterValid, dwValid, pwValid;

  logic [214:0] allOuts;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_stream_driver #(.ADDR_W(16)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_start                 (start),
    .i_cfg                   (cfg),
    .i_filter_base           (filterBase),
    .i_ifmap_base            (ifmapBase),
    .i_ipsum_base            (ipsumBase),
    .i_opsum_base            (opsumBase),
    .o_busy                  (busy),
    .o_done                  (done),
    .o_mem_ren               (memRen),
    .o_mem_raddr             (memRaddr),
    .i_mem_rdata             (memRdata),
    .o_mem_wen               (memWen),
    .o_mem_waddr             (memWaddr),
    .o_mem_wdata             (memWdata),
    .o_pe_en                 (peEn),
    .o_pe_config             (peConfig),
    .o_ifmap                 (ifmapD),
    .o_ifmap_valid           (ifmapValid),
    .i_ifmap_ready           (ifmapReady),
    .o_filter                (filterD),
    .o_filter_valid          (filterValid),
    .i_filter_ready          (filterReady),
    .o_depthwise_ipsum       (dwD),
    .o_depthwise_ipsum_valid (dwValid),
    .i_depthwise_ipsum_ready (dwReady),
    .o_pointwise_ipsum       (pwD),
    .o_pointwise_ipsum_valid (pwValid),
    .i_pointwise_ipsum_ready (pwReady),
    .i_opsum                 (opsum),
    .i_opsum_valid           (opsumValid),
    .o_opsum_ready           (opsumReady)
  );

  assign allOuts = {busy, done, memRen, memRaddr, memWen, memWaddr, memWdata, peEn, peConfig,
                    ifmapD, ifmapValid, filterD, filterValid, dwD, dwValid, pwD, pwValid,
                    opsumReady};

  // Buffer contents are a fixed scramble of the address so every word is traceable.
  function automatic logic [31:0] memf(input logic [15:0] a);
    return ({16'h0000, a} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic run_job(input string tag, input logic [12:0] c,
                         input logic [15:0] fb, input logic [15:0] ib,
                         input logic [15:0] pb, input logic [15:0] ob,
                         input bit stall, input int abortWrites, input bit poke);
    int          expKind[$];
    logic [15:0] expAddr[$];
    logic [15:0] expWaddr[$];
    logic [31:0] opv[$];
    int          obsKind[$];
    logic [31:0] obsData[$];
    logic [15:0] obsRaddr[$];
    logic [15:0] obsWaddr[$];
    logic [31:0] obsWdata[$];
    int          p, q, rs, u, f, n, widx, doneCnt, peEnCnt, peEnCyc, firstFv;
    int          onehotViol, stabViol, cyc, kind, prevKind;
    bit          dw, pend, seenDone, oHs, prevHs, busyMid, busyAtDone;
    logic [15:0] fp, ip, pp, op, pendAddr;
    logic [31:0] prevData, curData;
    logic [12:0] cfgEarly, cfgAtDone;
    logic [3:0]  vv, rr;
    logic [31:0] dd [4];

    dw = c[12];
    rs = int'(c[11:10]) + 1;
    u  = int'(c[9]) + 1;
    p  = int'(c[8:7]) + 1;
    f  = int'(c[6:2]);
    q  = int'(c[1:0]) + 1;
    fp = fb; ip = ib; pp = pb; op = ob;
    for (int i = 0; i < p * rs; i++) begin expKind.push_back(0); expAddr.push_back(fp); fp++; end
    for (int col = 0; col <= f; col++) begin
      n = (col == 0) ? rs : u;
      for (int i = 0; i < n; i++) begin expKind.push_back(1); expAddr.push_back(ip); ip++; end
      n = dw ? q : p;
      for (int i = 0; i < n; i++) begin expKind.push_back(2); expAddr.push_back(pp); pp++; end
      if (dw) for (int i = 0; i < p; i++) begin expKind.push_back(3); expAddr.push_back(pp); pp++; end
      for (int i = 0; i < p; i++) begin expWaddr.push_back(op); opv.push_back($urandom); op++; end
    end

    @(posedge clk); #1;
    start = 1'b1; cfg = c; filterBase = fb; ifmapBase = ib; ipsumBase = pb; opsumBase = ob;
    @(posedge clk); #1;
    start = 1'b0; cfg = 13'($urandom);
    filterBase = 16'($urandom); ifmapBase = 16'($urandom);
    ipsumBase = 16'($urandom); opsumBase = 16'($urandom);

    widx = 0; doneCnt = 0; peEnCnt = 0; peEnCyc = -1; firstFv = -1;
    onehotViol = 0; stabViol = 0; prevKind = -1; prevHs = 1'b1; prevData = '0;
    pend = 1'b0; pendAddr = '0; seenDone = 1'b0; oHs = 1'b0;
    busyMid = 1'b0; busyAtDone = 1'b1; cfgEarly = '0; cfgAtDone = '0;
    cyc = 1;
    while (!seenDone && cyc < 3000) begin
      memRdata = pend ? memf(pendAddr) : $urandom;
      filterReady = !stall || ($urandom_range(0, 9) >= 3);
      ifmapReady  = !stall || ($urandom_range(0, 9) >= 3);
      dwReady     = !stall || ($urandom_range(0, 9) >= 3);
      pwReady     = !stall || ($urandom_range(0, 9) >= 3);
      if (oHs) begin opsumValid = 1'b0; oHs = 1'b0; end
      if (!opsumValid && widx < opv.size() && (!stall || $urandom_range(0, 9) >= 3)) begin
        opsumValid = 1'b1; opsum = opv[widx];
      end
      start = poke && (cyc == 8);
      if (start) begin cfg = ~c; filterBase = ~fb; ipsumBase = ~pb; end

      @(negedge clk);
      vv = {pwValid, dwValid, ifmapValid, filterValid};
      rr = {pwReady, dwReady, ifmapReady, filterReady};
      dd[0] = filterD; dd[1] = ifmapD; dd[2] = dwD; dd[3] = pwD;
      if ($countones(vv) > 1) onehotViol++;
      if (prevKind >= 0 && !prevHs) begin
        if (!vv[prevKind] || dd[prevKind] !== prevData) stabViol++;
      end
      kind = -1;
      for (int k = 0; k < 4; k++) if (vv[k]) kind = k;
      if (kind >= 0) begin
        curData = dd[kind];
        prevKind = kind; prevData = curData; prevHs = rr[kind];
        if (rr[kind]) begin obsKind.push_back(kind); obsData.push_back(curData); end
      end else begin
        prevKind = -1;
      end
      if (memRen) begin obsRaddr.push_back(memRaddr); pend = 1'b1; pendAddr = memRaddr; end
      else pend = 1'b0;
      if (memWen) begin obsWaddr.push_back(memWaddr); obsWdata.push_back(memWdata); end
      if (opsumValid && opsumReady) begin widx++; oHs = 1'b1; end
      if (peEn) begin peEnCnt++; peEnCyc = cyc; end
      if (cyc == 2) begin cfgEarly = peConfig; busyMid = busy; end
      if (filterValid && firstFv < 0) firstFv = cyc;
      if (done) begin doneCnt++; seenDone = 1'b1; busyAtDone = busy; cfgAtDone = peConfig; end

      if (abortWrites >= 0 && widx == abortWrites && ifmapValid) begin
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (allOuts !== '0) begin
          fails++;
          $display("[TB] FAIL %s async_reset_outputs got=%h required=0", tag, allOuts);
        end
        filterReady = 1'b1; ifmapReady = 1'b1; dwReady = 1'b1; pwReady = 1'b1;
        opsumValid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    opsumValid = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) doneCnt++;
    end

    tests++;
    if (abortWrites >= 0) begin
      fails++;
      $display("[TB] FAIL %s abort_point got=not_reached required=ifmap_col1", tag);
    end
    tests++;
    if (!seenDone) begin
      fails++;
      $display("[TB] FAIL %s timeout got=no_done required=done_within_3000", tag);
    end
    tests++;
    if (obsKind.size() != expKind.size()) begin
      fails++;
      $display("[TB] FAIL %s beat_count got=%0d required=%0d", tag, obsKind.size(), expKind.size());
    end
    for (int i = 0; i < obsKind.size() && i < expKind.size(); i++) begin
      tests++;
      if (obsKind[i] !== expKind[i] || obsData[i] !== memf(expAddr[i])) begin
        fails++;
        $display("[TB] FAIL %s beat[%0d] got kind=%0d data=%h required kind=%0d data=%h",
                 tag, i, obsKind[i], obsData[i], expKind[i], memf(expAddr[i]));
      end
    end
    tests++;
    if (obsRaddr.size() != expAddr.size()) begin
      fails++;
      $display("[TB] FAIL %s read_count got=%0d required=%0d", tag, obsRaddr.size(), expAddr.size());
    end
    for (int i = 0; i < obsRaddr.size() && i < expAddr.size(); i++) begin
      tests++;
      if (obsRaddr[i] !== expAddr[i]) begin
        fails++;
        $display("[TB] FAIL %s raddr[%0d] got=%h required=%h", tag, i, obsRaddr[i], expAddr[i]);
      end
    end
    tests++;
    if (obsWaddr.size() != expWaddr.size()) begin
      fails++;
      $display("[TB] FAIL %s write_count got=%0d required=%0d", tag, obsWaddr.size(), expWaddr.size());
    end
    for (int i = 0; i < obsWaddr.size() && i < expWaddr.size(); i++) begin
      tests++;
      if (obsWaddr[i] !== expWaddr[i] || obsWdata[i] !== opv[i]) begin
        fails++;
        $display("[TB] FAIL %s write[%0d] got addr=%h data=%h required addr=%h data=%h",
                 tag, i, obsWaddr[i], obsWdata[i], expWaddr[i], opv[i]);
      end
    end
    tests++;
    if (onehotViol != 0) begin
      fails++;
      $display("[TB] FAIL %s valid_onehot got=%0d_cycles required=0", tag, onehotViol);
    end
    tests++;
    if (stabViol != 0) begin
      fails++;
      $display("[TB] FAIL %s stall_stability got=%0d_cycles required=0", tag, stabViol);
    end
    tests++;
    if (doneCnt != 1) begin
      fails++;
      $display("[TB] FAIL %s done_pulses got=%0d required=1", tag, doneCnt);
    end
    tests++;
    if (peEnCnt != 1 || peEnCyc != 1) begin
      fails++;
      $display("[TB] FAIL %s pe_en got count=%0d cycle=%0d required count=1 cycle=1", tag, peEnCnt, peEnCyc);
    end
    tests++;
    if (firstFv != 3) begin
      fails++;
      $display("[TB] FAIL %s first_filter_valid_cycle got=%0d required=3", tag, firstFv);
    end
    tests++;
    if (cfgEarly !== c || cfgAtDone !== c) begin
      fails++;
      $display("[TB] FAIL %s pe_config got early=%h end=%h required=%h", tag, cfgEarly, cfgAtDone, c);
    end
    tests++;
    if (busyMid !== 1'b1 || busyAtDone !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s busy got mid=%b at_done=%b required mid=1 at_done=0", tag, busyMid, busyAtDone);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++;
    if (allOuts !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got=%h required=0", allOuts);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (allOuts !== '0) begin
      fails++;
      $display("[TB] FAIL idle_outputs got=%h required=0", allOuts);
    end
  endtask

  task automatic test_conv();
    run_job("conv", {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd2}, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0, -1, 1'b0);
  endtask

  task automatic test_depthwise();
    run_job("depthwise", {1'b1, 2'd2, 1'b1, 2'd3, 5'd0, 2'd1}, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0, -1, 1'b0);
  endtask

  task automatic test_stalls();
    logic [12:0] c;
    run_job("conv_stall", {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd2}, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b1, -1, 1'b0);
    run_job("dw_stall", {1'b1, 2'd2, 1'b1, 2'd3, 5'd0, 2'd1}, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      c = 13'($urandom);
      c[6:2] = 5'($urandom_range(0, 3));
      run_job("random_stall", c, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, -1, 1'b0);
    end
  endtask

  task automatic test_reset_midop();
    run_job("midop_abort", {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd2}, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1'b0, 2, 1'b0);
    run_job("after_reset", {1'b0, 2'd2, 1'b0, 2'd1, 5'd1, 2'd2}, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1'b0, -1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_job("start_busy", {1'b1, 2'd1, 1'b0, 2'd1, 5'd2, 2'd3}, 16'h2200, 16'h3300, 16'h4400, 16'h5500, 1'b0, -1, 1'b1);
  endtask

  task automatic test_addr_wrap();
    run_job("addr_wrap", {1'b1, 2'd1, 1'b1, 2'd1, 5'd1, 2'd1}, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFF, 1'b0, -1, 1'b0);
  endtask

  initial begin
    start = 1'b0; cfg = '0;
    filterBase = '0; ifmapBase = '0; ipsumBase = '0; opsumBase = '0;
    memRdata = '0; opsum = '0; opsumValid = 1'b0;
    filterReady = 1'b1; ifmapReady = 1'b1; dwReady = 1'b1; pwReady = 1'b1;
    test_reset();
    test_conv();
    test_depthwise();
    test_stalls();
    test_reset_midop();
    test_start_while_busy();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
